// File: rtl/bsg_mesh_flow_tracker.sv
// Per-source in-flight monitor for one watched destination of an x_dim_p by y_dim_p mesh.
// Define BSG_MESH_FLOW_TRACKER_ORDER_EN to add per-source sequence-order checking.
module bsg_mesh_flow_tracker #(
    parameter int x_dim_p         = 4,
    parameter int y_dim_p         = 4,
    parameter int payload_width_p = 8,
    parameter int cnt_width_p     = 4,
    parameter int timeout_p       = 64,
    parameter int seq_width_p     = 4,
    localparam int x_cord_width_p = (x_dim_p > 1) ? $clog2(x_dim_p) : 1,
    localparam int y_cord_width_p = (y_dim_p > 1) ? $clog2(y_dim_p) : 1,
    localparam int cord_w_lp      = x_cord_width_p + y_cord_width_p,
    localparam int nodes_lp       = x_dim_p * y_dim_p,
    localparam int pkt_w_lp       = 2 * cord_w_lp + payload_width_p
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              en_i,
    input  logic [cord_w_lp-1:0]              watch_dst_i,
    input  logic [nodes_lp-1:0]               inj_v_i,
    input  logic [nodes_lp-1:0]               inj_ready_and_i,
    input  logic [nodes_lp*pkt_w_lp-1:0]      inj_data_i,
    input  logic [nodes_lp-1:0]               ej_v_i,
    input  logic [nodes_lp-1:0]               ej_ready_and_i,
    input  logic [nodes_lp*pkt_w_lp-1:0]      ej_data_i,
    output logic [nodes_lp*cnt_width_p-1:0]   inflight_o,
    output logic [4:0]                        err_o,
    output logic [cord_w_lp-1:0]              err_src_o,
    output logic                              done_o
);
    localparam int age_w_lp = $clog2(timeout_p + 1);
    localparam int src_lsb_lp = cord_w_lp + payload_width_p;

    typedef enum logic {IDLE, ARMED} state_e;

    state_e                                  state_q, state_d;
    logic [cord_w_lp-1:0]                    watch_q, watch_d;
    logic                                    delivered_q, delivered_d;
    logic [nodes_lp-1:0][cnt_width_p-1:0]    cnt_q, cnt_d;
    logic [nodes_lp-1:0][age_w_lp-1:0]       age_q, age_d;
    logic [4:0]                              err_q, err_d;
    logic [cord_w_lp-1:0]                    err_src_q, err_src_d;
`ifdef BSG_MESH_FLOW_TRACKER_ORDER_EN
    logic [nodes_lp-1:0][seq_width_p-1:0]    exp_q, exp_d;
`endif

    logic                 counting;
    logic [nodes_lp-1:0]  inc, dec, ev;
    logic                 ovf_any, unf_any, to_any, mis_any, ord_any;
    logic [pkt_w_lp-1:0]  pkt;
    logic                 unused_ok;

    // Cords may not fill their field on non-power-of-two meshes, so compare fields, not ids.
    function automatic logic cord_is(input logic [cord_w_lp-1:0] c, input int id);
        return (c[x_cord_width_p-1:0] == x_cord_width_p'(id % x_dim_p))
            && (c[cord_w_lp-1:x_cord_width_p] == y_cord_width_p'(id / x_dim_p));
    endfunction

    function automatic logic [cord_w_lp-1:0] id_to_cord(input int id);
        return {y_cord_width_p'(id / x_dim_p), x_cord_width_p'(id % x_dim_p)};
    endfunction

    assign counting  = (state_q == ARMED) && en_i;
    assign unused_ok = ^{inj_data_i, ej_data_i, seq_width_p[0]};

    always_comb begin
        state_d     = state_q;
        watch_d     = watch_q;
        delivered_d = delivered_q;
        cnt_d       = cnt_q;
        age_d       = age_q;
        err_d       = err_q;
        err_src_d   = err_src_q;
        inc = '0; dec = '0; ev = '0;
        ovf_any = 1'b0; unf_any = 1'b0; to_any = 1'b0; mis_any = 1'b0; ord_any = 1'b0;
        pkt = '0;
`ifdef BSG_MESH_FLOW_TRACKER_ORDER_EN
        exp_d = exp_q;
`endif
        case (state_q)
            IDLE: if (en_i) begin
                state_d     = ARMED;
                watch_d     = watch_dst_i;
                delivered_d = 1'b0;
                cnt_d       = '0;
                age_d       = '0;
`ifdef BSG_MESH_FLOW_TRACKER_ORDER_EN
                exp_d       = '0;
`endif
            end
            default: if (!en_i) state_d = IDLE;
        endcase

        if (counting) begin
            for (int s = 0; s < nodes_lp; s++) begin
                pkt = inj_data_i[s*pkt_w_lp +: pkt_w_lp];
                if (inj_v_i[s] && inj_ready_and_i[s] && pkt[cord_w_lp-1:0] == watch_q)
                    inc[s] = 1'b1;
            end
            for (int d = 0; d < nodes_lp; d++) begin
                pkt = ej_data_i[d*pkt_w_lp +: pkt_w_lp];
                if (ej_v_i[d] && ej_ready_and_i[d]) begin
                    for (int s = 0; s < nodes_lp; s++) begin
                        if (cord_is(pkt[pkt_w_lp-1:src_lsb_lp], s)) begin
                            if (!cord_is(pkt[cord_w_lp-1:0], d)) begin
                                mis_any = 1'b1;
                                ev[s]   = 1'b1;
                            end
                            if (cord_is(watch_q, d)) begin
                                dec[s] = 1'b1;
`ifdef BSG_MESH_FLOW_TRACKER_ORDER_EN
                                if (pkt[cord_w_lp +: seq_width_p] != exp_q[s]) begin
                                    ord_any = 1'b1;
                                    ev[s]   = 1'b1;
                                end
                                exp_d[s] = exp_q[s] + 1'b1;
`endif
                            end
                        end
                    end
                end
            end
            for (int s = 0; s < nodes_lp; s++) begin
                if (dec[s] && cnt_q[s] == '0) begin
                    unf_any = 1'b1;
                    ev[s]   = 1'b1;
                end
                if (inc[s] && !dec[s] && cnt_q[s] == '1) begin
                    ovf_any = 1'b1;
                    ev[s]   = 1'b1;
                end
                if (cnt_q[s] == '0 || dec[s]) begin
                    age_d[s] = '0;
                end else if (age_q[s] != age_w_lp'(timeout_p)) begin
                    age_d[s] = age_q[s] + 1'b1;
                    if (age_q[s] == age_w_lp'(timeout_p - 1)) begin
                        to_any = 1'b1;
                        ev[s]  = 1'b1;
                    end
                end
                cnt_d[s] = cnt_q[s] + cnt_width_p'(inc[s]) - cnt_width_p'(dec[s]);
            end
            if (|dec) delivered_d = 1'b1;
            err_d = err_q | {ord_any, to_any, mis_any, unf_any, ovf_any};
            // Walk down so the lowest source id with an event is the one kept.
            if (err_q == '0 && err_d != '0) begin
                for (int s = nodes_lp - 1; s >= 0; s--)
                    if (ev[s]) err_src_d = id_to_cord(s);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            watch_q     <= '0;
            delivered_q <= 1'b0;
            cnt_q       <= '0;
            age_q       <= '0;
            err_q       <= '0;
            err_src_q   <= '0;
`ifdef BSG_MESH_FLOW_TRACKER_ORDER_EN
            exp_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            watch_q     <= watch_d;
            delivered_q <= delivered_d;
            cnt_q       <= cnt_d;
            age_q       <= age_d;
            err_q       <= err_d;
            err_src_q   <= err_src_d;
`ifdef BSG_MESH_FLOW_TRACKER_ORDER_EN
            exp_q       <= exp_d;
`endif
        end
    end

    assign inflight_o = cnt_q;
    assign err_o      = err_q;
    assign err_src_o  = err_src_q;
    assign done_o     = (state_q == ARMED) && delivered_q && (cnt_q == '0) && (err_q == '0);

endmodule

// File: tb/tb_bsg_mesh_flow_tracker.sv
// Bench for bsg_mesh_flow_tracker: directed vector table, corner sequences, randomized traffic vs model.
module tb_bsg_mesh_flow_tracker;
    localparam int XD = 4, YD = 4, PW = 8, CW = 4, TO = 64, SW = 4;
    localparam int C = 4, N = XD * YD, W = 2 * C + PW;

    logic clk = 1'b0;
    logic reset, en_i;
    logic [C-1:0] watch;
    logic [N-1:0] inj_v, inj_r, ej_v, ej_r;
    logic [N*W-1:0] inj_d, ej_d;
    logic [N*CW-1:0] inflight;
    logic [4:0] err;
    logic [C-1:0] err_src;
    logic done;

    bsg_mesh_flow_tracker #(.x_dim_p(XD), .y_dim_p(YD), .payload_width_p(PW),
        .cnt_width_p(CW), .timeout_p(TO), .seq_width_p(SW)) dut (
        .clk(clk), .reset(reset), .en_i(en_i), .watch_dst_i(watch),
        .inj_v_i(inj_v), .inj_ready_and_i(inj_r), .inj_data_i(inj_d),
        .ej_v_i(ej_v), .ej_ready_and_i(ej_r), .ej_data_i(ej_d),
        .inflight_o(inflight), .err_o(err), .err_src_o(err_src), .done_o(done));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model: per-source counts and ages as plain integers.
    int m_cnt[N], m_age[N], m_exp[N];
    bit m_armed, m_deliv;
    logic [4:0] m_err;
    logic [C-1:0] m_err_src, m_watch;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // 4x4 mesh: node id and cord are numerically equal.
    function automatic logic [W-1:0] pkt(input int src, input int pay, input int dst);
        return {C'(src), PW'(pay), C'(dst)};
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < N; s++) begin m_cnt[s] = 0; m_age[s] = 0; m_exp[s] = 0; end
        m_deliv = 0;
    endfunction

    function automatic void model_step();
        bit counting;
        int inc[N], dec[N];
        bit [N-1:0] evs;
        logic [4:0] ne;
        logic [W-1:0] p;
        if (reset) begin
            model_clear();
            m_armed = 0; m_err = '0; m_err_src = '0; m_watch = '0;
            return;
        end
        counting = m_armed && en_i;
        if (!m_armed && en_i) begin m_armed = 1; model_clear(); m_watch = watch; end
        else if (m_armed && !en_i) m_armed = 0;
        if (!counting) return;
        evs = '0; ne = '0;
        for (int s = 0; s < N; s++) begin inc[s] = 0; dec[s] = 0; end
        for (int s = 0; s < N; s++) begin
            p = inj_d[s*W +: W];
            if (inj_v[s] && inj_r[s] && p[C-1:0] == m_watch) inc[s] = 1;
        end
        for (int d = 0; d < N; d++) begin
            p = ej_d[d*W +: W];
            if (ej_v[d] && ej_r[d]) begin
                if (int'(p[C-1:0]) != d) begin ne[2] = 1; evs[p[W-1:W-C]] = 1; end
                if (d == int'(m_watch)) begin
                    dec[p[W-1:W-C]] = 1;
`ifdef BSG_MESH_FLOW_TRACKER_ORDER_EN
                    if (int'(p[C +: SW]) != m_exp[p[W-1:W-C]]) begin ne[4] = 1; evs[p[W-1:W-C]] = 1; end
                    m_exp[p[W-1:W-C]] = (m_exp[p[W-1:W-C]] + 1) % (1 << SW);
`endif
                end
            end
        end
        for (int s = 0; s < N; s++) begin
            if (dec[s] == 1 && m_cnt[s] == 0) begin ne[1] = 1; evs[s] = 1; end
            if (inc[s] == 1 && dec[s] == 0 && m_cnt[s] == (1 << CW) - 1) begin ne[0] = 1; evs[s] = 1; end
            if (m_cnt[s] == 0 || dec[s] == 1) m_age[s] = 0;
            else if (m_age[s] < TO) begin
                m_age[s]++;
                if (m_age[s] == TO) begin ne[3] = 1; evs[s] = 1; end
            end
            m_cnt[s] = (m_cnt[s] + inc[s] - dec[s] + (1 << CW)) % (1 << CW);
            if (dec[s] == 1) m_deliv = 1;
        end
        if (m_err == '0 && ne != '0) begin
            for (int s = N - 1; s >= 0; s--) if (evs[s]) m_err_src = C'(s);
        end
        m_err = m_err | ne;
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [N*CW-1:0] exp_inf;
        bit all_zero = 1;
        for (int s = 0; s < N; s++) begin
            exp_inf[s*CW +: CW] = CW'(m_cnt[s]);
            if (m_cnt[s] != 0) all_zero = 0;
        end
        chk({tag, "_inflight"}, 64'(inflight), 64'(exp_inf));
        chk({tag, "_err"}, 64'(err), 64'(m_err));
        chk({tag, "_err_src"}, 64'(err_src), 64'(m_err_src));
        chk({tag, "_done"}, 64'(done), 64'(m_armed && m_deliv && all_zero && m_err == '0));
    endtask

    task automatic clear_inputs();
        inj_v = '0; ej_v = '0; inj_r = '1; ej_r = '1; inj_d = '0; ej_d = '0;
    endtask

    task automatic reset_arm(input int w);
        clear_inputs();
        reset = 1; en_i = 0; step();
        reset = 0; en_i = 1; watch = C'(w); step();
    endtask

    typedef struct {
        int inj_n; int inj_dst;
        int ej_n; int ej_src; int ej_dst;
        logic [63:0] exp_inf; logic [4:0] exp_err; logic exp_done;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{0, 7, -1, 0, 0, 64'h1, 5'b0, 1'b0};
        tbl[1] = '{0, 7, -1, 0, 0, 64'h2, 5'b0, 1'b0};
        tbl[2] = '{0, 7, -1, 0, 0, 64'h3, 5'b0, 1'b0};
        tbl[3] = '{-1, 0, 7, 0, 7, 64'h2, 5'b0, 1'b0};
        tbl[4] = '{-1, 0, 7, 0, 7, 64'h1, 5'b0, 1'b0};
        tbl[5] = '{-1, 0, 7, 0, 7, 64'h0, 5'b0, 1'b1};
        tbl[6] = '{1, 5, -1, 0, 0, 64'h0, 5'b0, 1'b1};
        tbl[7] = '{-1, 0, 5, 1, 5, 64'h0, 5'b0, 1'b1};

        clear_inputs();
        watch = '0; en_i = 0; reset = 1;
        step();
        reset = 0;
        chk("rst_inflight", 64'(inflight), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_err_src", 64'(err_src), 64'h0);
        chk("rst_done", 64'(done), 64'h0);

        // Basic flow: arm on 7, three injections from node 0 then three deliveries.
        en_i = 1; watch = 4'd7; step();
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            if (tbl[i].inj_n >= 0) begin
                inj_v[tbl[i].inj_n] = 1;
                inj_d[tbl[i].inj_n*W +: W] = pkt(tbl[i].inj_n, i, tbl[i].inj_dst);
            end
            if (tbl[i].ej_n >= 0) begin
                ej_v[tbl[i].ej_n] = 1;
                ej_d[tbl[i].ej_n*W +: W] = pkt(tbl[i].ej_src, 0, tbl[i].ej_dst);
            end
            step();
            chk($sformatf("vec%0d_inflight", i), 64'(inflight), tbl[i].exp_inf);
            chk($sformatf("vec%0d_err", i), 64'(err), 64'(tbl[i].exp_err));
            chk($sformatf("vec%0d_done", i), 64'(done), 64'(tbl[i].exp_done));
        end

        // Phantom delivery from source 5.
        reset_arm(7);
        ej_v[7] = 1; ej_d[7*W +: W] = pkt(5, 0, 7);
        step(); clear_inputs();
        chk("unf_err", 64'(err), 64'b00010);
        chk("unf_src", 64'(err_src), 64'd5);
        chk("unf_cnt_wrap", 64'(inflight[5*CW +: CW]), 64'hf);

        // Misroute: node 3 ejects a packet addressed to 7.
        reset_arm(7);
        ej_v[3] = 1; ej_d[3*W +: W] = pkt(9, 0, 7);
        step(); clear_inputs();
        chk("mis_err", 64'(err), 64'b00100);
        chk("mis_src", 64'(err_src), 64'd9);

        // Timeout: one packet from node 2 never delivered.
        reset_arm(7);
        inj_v[2] = 1; inj_d[2*W +: W] = pkt(2, 0, 7);
        step(); clear_inputs();
        repeat (63) step();
        chk("to_not_yet", 64'(err), 64'h0);
        step();
        chk("to_err", 64'(err), 64'b01000);
        chk("to_src", 64'(err_src), 64'd2);
        chk("to_cnt", 64'(inflight[2*CW +: CW]), 64'h1);

        // Order: source 1 delivers seq 0 then seq 2.
        reset_arm(7);
        inj_v[1] = 1; inj_d[1*W +: W] = pkt(1, 0, 7); step();
        inj_d[1*W +: W] = pkt(1, 1, 7); step();
        clear_inputs();
        ej_v[7] = 1; ej_d[7*W +: W] = pkt(1, 0, 7); step();
        chk("ord_first", 64'(err), 64'h0);
        ej_d[7*W +: W] = pkt(1, 2, 7); step(); clear_inputs();
`ifdef BSG_MESH_FLOW_TRACKER_ORDER_EN
        chk("ord_second", 64'(err), 64'b10000);
        chk("ord_src", 64'(err_src), 64'd1);
`else
        chk("ord_second", 64'(err), 64'h0);
        chk("ord_done", 64'(done), 64'h1);
`endif

        // Overflow after 16 injections, then reset while traffic continues.
        reset_arm(7);
        inj_v[0] = 1; inj_d[0 +: W] = pkt(0, 0, 7);
        repeat (15) step();
        chk("ovf_15_cnt", 64'(inflight[0 +: CW]), 64'hf);
        chk("ovf_15_err", 64'(err), 64'h0);
        step();
        chk("ovf_err", 64'(err), 64'b00001);
        chk("ovf_cnt_wrap", 64'(inflight[0 +: CW]), 64'h0);
        chk("ovf_src", 64'(err_src), 64'd0);
        reset = 1; step(); reset = 0;
        chk("rst2_inflight", 64'(inflight), 64'h0);
        chk("rst2_err", 64'(err), 64'h0);
        chk("rst2_err_src", 64'(err_src), 64'h0);
        chk("rst2_done", 64'(done), 64'h0);
        clear_inputs();

        // Randomized traffic: run 0 mostly legal, run 1 busier with misroutes.
        for (int run = 0; run < 2; run++) begin
            int inj_pct = (run == 0) ? 4 : 12;
            int mis_pct = (run == 0) ? 0 : 5;
            reset_arm($urandom_range(0, N - 1));
            check_model("arm");
            for (int cyc = 0; cyc < 350; cyc++) begin
                clear_inputs();
                if (!en_i) begin en_i = 1; watch = C'($urandom_range(0, N - 1)); end
                else if ($urandom_range(0, 99) < 2) en_i = 0;
                for (int n = 0; n < N; n++) begin
                    int dst, src;
                    inj_r[n] = ($urandom_range(0, 3) != 0);
                    ej_r[n]  = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 99) < inj_pct) begin
                        inj_v[n] = 1;
                        dst = ($urandom_range(0, 1) == 0) ? int'(watch) : $urandom_range(0, N - 1);
                        inj_d[n*W +: W] = pkt(n, $urandom_range(0, 255), dst);
                    end
                    src = $urandom_range(0, N - 1);
                    if (n == int'(m_watch) && $urandom_range(0, 9) != 0) begin
                        for (int k = 0; k < N; k++)
                            if (m_cnt[(src + k) % N] != 0) begin src = (src + k) % N; break; end
                    end
                    if ((n == int'(m_watch) && $urandom_range(0, 99) < 60) ||
                        $urandom_range(0, 99) < 10) begin
                        ej_v[n] = 1;
                        dst = ($urandom_range(0, 99) < mis_pct) ? $urandom_range(0, N - 1) : n;
                        ej_d[n*W +: W] = pkt(src, $urandom_range(0, 255), dst);
                    end
                end
                step();
                check_model($sformatf("rnd%0d_c%0d", run, cyc));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
